// File: rtl/cpu_datamem_arb.sv
// ============================================================================
// cpu_datamem_arb : CPU / accelerator arbiter in front of the data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_datamem_arb #(
    parameter int          MAX_WAIT = 4,
    parameter logic [15:0] ACB_LO   = 16'h5000,
    parameter logic [15:0] ACB_HI   = 16'h81FC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [15:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic         cpu_gnt_o,
    output logic         cpu_rvalid_o,
    output logic [31:0]  cpu_rdata_o,
    output logic         cpu_err_o,
    input  logic         acc_req_i,
    input  logic         acc_we_i,
    input  logic [15:0]  acc_addr_i,
    input  logic [31:0]  acc_wdata_i,
    output logic         acc_gnt_o,
    output logic         acc_rvalid_o,
    output logic [511:0] acc_rdata_o,
    output logic         acc_err_o,
    output logic [15:0]  mem_addr_o,
    output logic [31:0]  mem_wrt_data_o,
    output logic         mem_wrt_en_o,
    input  logic [511:0] mem_rd_data_i
);

    localparam int          WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [15:0] CPU_TOP   = 16'hFFFC;
    localparam logic [15:0] ACC_RD_TOP = 16'hFFC0;

    logic              w_cpu_gnt, w_acc_gnt;
    logic              w_cpu_legal, w_acc_legal, w_legal, w_we;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              prio_acc_q, prio_acc_d;
    logic              cpu_rd_q, acc_rd_q, rd_legal_q;
    logic              cpu_err_q, acc_err_q;

    // Grants are gated by rst_n so nothing reaches memory while held in reset.
    assign w_acc_gnt = rst_n && acc_req_i && (!cpu_req_i || prio_acc_q);
    assign w_cpu_gnt = rst_n && cpu_req_i && !w_acc_gnt;

    assign w_cpu_legal = (cpu_addr_i <= CPU_TOP);
    assign w_acc_legal = acc_we_i ? ((acc_addr_i >= ACB_LO) && (acc_addr_i <= ACB_HI))
                                  : (acc_addr_i <= ACC_RD_TOP);
    assign w_legal     = w_acc_gnt ? w_acc_legal : w_cpu_legal;
    assign w_we        = w_acc_gnt ? acc_we_i    : cpu_we_i;

    always_comb begin
        mem_addr_o     = 16'h0000;
        mem_wrt_data_o = 32'h0000_0000;
        if (w_acc_gnt) begin
            mem_addr_o     = acc_addr_i;
            mem_wrt_data_o = acc_wdata_i;
        end else if (w_cpu_gnt) begin
            mem_addr_o     = cpu_addr_i;
            mem_wrt_data_o = cpu_wdata_i;
        end
    end

    assign mem_wrt_en_o = (w_cpu_gnt || w_acc_gnt) && w_we && w_legal;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        prio_acc_d = prio_acc_q;
        if (w_acc_gnt) begin
            wait_cnt_d = '0;
            prio_acc_d = 1'b0;
        end else if (acc_req_i) begin
            if (wait_cnt_q < WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            // Priority takes effect the cycle the counter reaches its limit.
            if (wait_cnt_d == WAIT_MAX) begin
                prio_acc_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            prio_acc_q <= 1'b0;
            cpu_rd_q   <= 1'b0;
            acc_rd_q   <= 1'b0;
            rd_legal_q <= 1'b0;
            cpu_err_q  <= 1'b0;
            acc_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            prio_acc_q <= prio_acc_d;
            cpu_rd_q   <= w_cpu_gnt && !cpu_we_i;
            acc_rd_q   <= w_acc_gnt && !acc_we_i;
            rd_legal_q <= w_legal;
            cpu_err_q  <= w_cpu_gnt && !w_cpu_legal;
            acc_err_q  <= w_acc_gnt && !w_acc_legal;
        end
    end

    assign cpu_gnt_o    = w_cpu_gnt;
    assign acc_gnt_o    = w_acc_gnt;
    assign cpu_rvalid_o = cpu_rd_q;
    assign acc_rvalid_o = acc_rd_q;
    assign cpu_err_o    = cpu_err_q;
    assign acc_err_o    = acc_err_q;
    // Illegal reads complete with zero data rather than whatever memory returned.
    assign cpu_rdata_o  = (cpu_rd_q && rd_legal_q) ? mem_rd_data_i[31:0] : 32'h0000_0000;
    assign acc_rdata_o  = (acc_rd_q && rd_legal_q) ? mem_rd_data_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_cpu_datamem_arb.sv
// ============================================================================
// tb_cpu_datamem_arb : directed self-checking bench with a byte memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_datamem_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req, cpu_we, acc_req, acc_we;
    logic [15:0]  cpu_addr, acc_addr;
    logic [31:0]  cpu_wdata, acc_wdata;
    logic         cpu_gnt, cpu_rvalid, cpu_err, acc_gnt, acc_rvalid, acc_err;
    logic [31:0]  cpu_rdata;
    logic [511:0] acc_rdata;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wrt_data;
    logic         mem_wrt_en;
    logic [511:0] mem_rd_data;

    logic [7:0]   tb_mem [0:65535];
    int           n_assert = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    cpu_datamem_arb #(.MAX_WAIT(4), .ACB_LO(16'h5000), .ACB_HI(16'h81FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err),
        .acc_req_i(acc_req), .acc_we_i(acc_we), .acc_addr_i(acc_addr), .acc_wdata_i(acc_wdata),
        .acc_gnt_o(acc_gnt), .acc_rvalid_o(acc_rvalid), .acc_rdata_o(acc_rdata), .acc_err_o(acc_err),
        .mem_addr_o(mem_addr), .mem_wrt_data_o(mem_wrt_data), .mem_wrt_en_o(mem_wrt_en),
        .mem_rd_data_i(mem_rd_data)
    );

    // Single-port memory: 4-byte write, 64-byte registered read from the same address.
    always @(posedge clk) begin
        if (mem_wrt_en) begin
            for (int k = 0; k < 4; k++) tb_mem[16'(mem_addr + k)] <= mem_wrt_data[8*k +: 8];
        end
        for (int k = 0; k < 64; k++) mem_rd_data[8*k +: 8] <= tb_mem[16'(mem_addr + k)];
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
        acc_req = 1'b0; acc_we = 1'b0; acc_addr = 16'h0; acc_wdata = 32'h0;
    endtask

    task automatic cpu_issue(input logic we, input logic [15:0] a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic acc_issue(input logic we, input logic [15:0] a, input logic [31:0] d);
        acc_req = 1'b1; acc_we = we; acc_addr = a; acc_wdata = d;
    endtask

    logic [511:0] exp_line;
    logic [31:0]  word;

    initial begin
        for (int i = 0; i < 65536; i++) tb_mem[i] = 8'h00;
        mem_rd_data = '0;
        idle();
        rst_n = 1'b0;

        // Reset: a request while in reset is not granted.
        cpu_issue(1'b1, 16'h0010, 32'h1234_5678);
        #3;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_wrt_en", mem_wrt_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rvalid", {cpu_rvalid, acc_rvalid, cpu_err, acc_err}, 0);
        chk("rst_rdata", {cpu_rdata, acc_rdata}, 0);
        tick(); tick();
        idle();
        rst_n = 1'b1;
        tick();

        // CPU write then read-back in the following cycle.
        cpu_issue(1'b1, 16'h1000, 32'hDEAD_BEEF);
        #3;
        chk("wr_cpu_gnt", cpu_gnt, 1);
        chk("wr_acc_gnt", acc_gnt, 0);
        chk("wr_en", mem_wrt_en, 1);
        chk("wr_addr", mem_addr, 16'h1000);
        chk("wr_data", mem_wrt_data, 32'hDEAD_BEEF);
        tick();
        chk("wr_no_rvalid", cpu_rvalid, 0);
        cpu_issue(1'b0, 16'h1000, 32'h0);
        #3;
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_no_wrt_en", mem_wrt_en, 0);
        tick();
        idle();
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_cpu_err", cpu_err, 0);
        chk("rd_acc_rvalid", acc_rvalid, 0);
        tick();
        chk("rd_rvalid_drop", cpu_rvalid, 0);

        // CPU fills 16 words at 0x5000, accel reads the 64-byte line.
        exp_line = '0;
        for (int i = 0; i < 16; i++) begin
            word = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
            exp_line[32*i +: 32] = word;
            cpu_issue(1'b1, 16'h5000 + 16'(4*i), word);
            tick();
        end
        idle();
        acc_issue(1'b0, 16'h5000, 32'h0);
        #3;
        chk("line_acc_gnt", acc_gnt, 1);
        chk("line_mem_addr", mem_addr, 16'h5000);
        tick();
        idle();
        chk("line_acc_rvalid", acc_rvalid, 1);
        chk("line_acc_rdata", acc_rdata, exp_line);
        chk("line_cpu_rvalid", cpu_rvalid, 0);
        chk("line_cpu_rdata", cpu_rdata, 0);
        tick();

        // Continuous contention: accel wins every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            cpu_issue(1'b0, 16'h1000, 32'h0);
            acc_issue(1'b0, 16'h5000, 32'h0);
            #3;
            chk($sformatf("cont_acc_gnt_%0d", i), acc_gnt, (i % 5 == 4));
            chk($sformatf("cont_cpu_gnt_%0d", i), cpu_gnt, (i % 5 != 4));
            tick();
        end
        idle();
        tick();

        // Range violations: granted, no write, zero data, err one cycle later.
        acc_issue(1'b1, 16'h4FFC, 32'h5555_AAAA);
        #3;
        chk("bad_accw_gnt", acc_gnt, 1);
        chk("bad_accw_wrt_en", mem_wrt_en, 0);
        tick();
        chk("bad_accw_err", acc_err, 1);
        chk("bad_accw_rvalid", acc_rvalid, 0);
        acc_issue(1'b0, 16'hFFC1, 32'h0);
        #3;
        chk("bad_accr_gnt", acc_gnt, 1);
        tick();
        idle();
        chk("bad_accr_rvalid", acc_rvalid, 1);
        chk("bad_accr_rdata", acc_rdata, 0);
        chk("bad_accr_err", acc_err, 1);
        cpu_issue(1'b1, 16'hFFFE, 32'h0BAD_0BAD);
        #3;
        chk("bad_cpuw_gnt", cpu_gnt, 1);
        chk("bad_cpuw_wrt_en", mem_wrt_en, 0);
        tick();
        idle();
        chk("bad_cpuw_err", cpu_err, 1);
        chk("bad_acc_err_clear", acc_err, 0);
        tick();
        chk("bad_cpu_err_clear", cpu_err, 0);

        // Range boundaries that are legal.
        acc_issue(1'b1, 16'h81FC, 32'hCAFE_F00D);
        #3;
        chk("acb_hi_wrt_en", mem_wrt_en, 1);
        tick();
        chk("acb_hi_err", acc_err, 0);
        acc_issue(1'b0, 16'hFFC0, 32'h0);
        tick();
        idle();
        chk("accr_top_err", acc_err, 0);
        chk("accr_top_rvalid", acc_rvalid, 1);
        cpu_issue(1'b0, 16'h81FC, 32'h0);
        tick();
        idle();
        chk("acb_hi_readback", cpu_rdata, 32'hCAFE_F00D);

        // Alternating lone requests are granted immediately, never waiting.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) cpu_issue(1'b0, 16'h0100, 32'h0);
            else            acc_issue(1'b0, 16'h0200, 32'h0);
            #3;
            chk($sformatf("alt_gnt_%0d", i), (i % 2 == 0) ? cpu_gnt : acc_gnt, 1);
            tick();
            idle();
            chk($sformatf("alt_wait_%0d", i), dut.wait_cnt_q, 0);
            tick();
        end

        // Reset asserted while a read result is being returned.
        cpu_issue(1'b0, 16'h1000, 32'h0);
        tick();
        chk("mid_rvalid_pre", cpu_rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rvalid", cpu_rvalid, 0);
        chk("mid_gnt", cpu_gnt, 0);
        chk("mid_wrt_en", mem_wrt_en, 0);
        chk("mid_rdata", cpu_rdata, 0);
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        chk("post_rst_rvalid", cpu_rvalid, 0);
        tick();
        chk("post_rst_rvalid2", cpu_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
